// File: rtl/mod_pkg.sv
// Shared definitions for the modulator front end: arbiter states, default block size
// and the Q15 +/-0.707 constraint-point values used by the QPSK modulator benches.
package mod_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StOwn0 = 2'd1,
    StOwn1 = 2'd2
  } arb_state_e;

  localparam int unsigned DefaultBlockBits = 192;

  localparam logic signed [15:0] Q15Pos = 16'sh5A7F;
  localparam logic signed [15:0] Q15Neg = 16'shA581;

  // QPSK axis value for one bit: 0 -> +0.707, 1 -> -0.707.
  function automatic logic signed [15:0] q15_axis(input logic b);
    return b ? Q15Neg : Q15Pos;
  endfunction

endpackage

// File: rtl/mod_block_arbiter_if.sv
// Requester/modulator handshake bundle around mod_block_arbiter.
// slave = arbiter side, master = requesters plus modulator side.
interface mod_block_arbiter_if;

  logic Req0;
  logic Req1;
  logic Valid_in0;
  logic Valid_in1;
  logic Data_in0;
  logic Data_in1;
  logic Ready_in0;
  logic Ready_in1;
  logic Valid_out;
  logic Data_out;
  logic Ready_out;
  logic Grant0;
  logic Grant1;
  logic Block_done;
  logic Busy;

  modport slave (
    input  Req0, Req1, Valid_in0, Valid_in1, Data_in0, Data_in1, Ready_out,
    output Ready_in0, Ready_in1, Valid_out, Data_out, Grant0, Grant1, Block_done, Busy
  );

  modport master (
    output Req0, Req1, Valid_in0, Valid_in1, Data_in0, Data_in1, Ready_out,
    input  Ready_in0, Ready_in1, Valid_out, Data_out, Grant0, Grant1, Block_done, Busy
  );

endinterface

// File: rtl/mod_rr_pick.sv
// Two-way winner selection: single requester wins outright; ties go to requester 0
// under strict priority, otherwise to the requester not served last.
module mod_rr_pick #(
  parameter bit STRICT_PRI = 1'b0
) (
  input  logic Req0,
  input  logic Req1,
  input  logic pointer,
  output logic winner,
  output logic valid
);

  always_comb begin
    valid  = Req0 | Req1;
    winner = Req1;
    if (Req0 && Req1) begin
      winner = STRICT_PRI ? 1'b0 : ~pointer;
    end
  end

endmodule

// File: rtl/mod_block_arbiter.sv
// Block-granular arbiter sharing the QPSK modulator serial input between two bit sources.
// Ownership changes only in idle or on the final beat of a block, never mid-symbol.
module mod_block_arbiter
  import mod_pkg::*;
#(
  parameter int unsigned BLOCK_BITS = DefaultBlockBits,
  parameter bit          STRICT_PRI = 1'b0,
  parameter int unsigned CNT_W      = 8
) (
  input  logic                clk,
  input  logic                rstn,
  mod_block_arbiter_if.slave  bus
);

  localparam logic [CNT_W-1:0] LastBeat = CNT_W'(BLOCK_BITS - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] bit_cnt;
  logic             pointer;

  logic valid_out, data_out, ready_in0, ready_in1;
  logic beat, final_beat, arb_en;
  logic pick_winner, pick_valid;

  mod_rr_pick #(
    .STRICT_PRI (STRICT_PRI)
  ) u_pick (
    .Req0    (bus.Req0),
    .Req1    (bus.Req1),
    .pointer (pointer),
    .winner  (pick_winner),
    .valid   (pick_valid)
  );

  // Zero-latency mux from the owning requester to the modulator.
  always_comb begin
    valid_out = 1'b0;
    data_out  = 1'b0;
    ready_in0 = 1'b0;
    ready_in1 = 1'b0;
    unique case (state)
      StOwn0: begin
        valid_out = bus.Valid_in0;
        data_out  = bus.Data_in0;
        ready_in0 = bus.Ready_out;
      end
      StOwn1: begin
        valid_out = bus.Valid_in1;
        data_out  = bus.Data_in1;
        ready_in1 = bus.Ready_out;
      end
      default: ;
    endcase
  end

  assign beat       = valid_out & bus.Ready_out;
  assign final_beat = beat && (bit_cnt == LastBeat);
  assign arb_en     = (state == StIdle) || final_beat;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state   <= StIdle;
      bit_cnt <= '0;
      pointer <= 1'b1;
    end else if (arb_en) begin
      bit_cnt <= '0;
      if (pick_valid) begin
        state   <= pick_winner ? StOwn1 : StOwn0;
        pointer <= pick_winner;
      end else begin
        state <= StIdle;
      end
    end else if (beat) begin
      bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  assign bus.Valid_out  = valid_out;
  assign bus.Data_out   = data_out;
  assign bus.Ready_in0  = ready_in0;
  assign bus.Ready_in1  = ready_in1;
  assign bus.Grant0     = (state == StOwn0);
  assign bus.Grant1     = (state == StOwn1);
  assign bus.Busy       = (state == StOwn0) || (state == StOwn1);
  assign bus.Block_done = final_beat;

endmodule

// File: tb/tb_mod_block_arbiter.sv
// Drives a round-robin and a strict-priority arbiter with the same stimulus and compares
// both against a per-cycle ownership model plus directed block-level expectations.
module tb_mod_block_arbiter;

  localparam int BB = 192;

  logic clk;
  logic rstn;
  logic req0, req1, vin0, vin1, din0, din1, rdy;

  int n_checks = 0;
  int n_pass   = 0;

  mod_block_arbiter_if bus_rr ();
  mod_block_arbiter_if bus_sp ();

  assign bus_rr.Req0 = req0;      assign bus_sp.Req0 = req0;
  assign bus_rr.Req1 = req1;      assign bus_sp.Req1 = req1;
  assign bus_rr.Valid_in0 = vin0; assign bus_sp.Valid_in0 = vin0;
  assign bus_rr.Valid_in1 = vin1; assign bus_sp.Valid_in1 = vin1;
  assign bus_rr.Data_in0 = din0;  assign bus_sp.Data_in0 = din0;
  assign bus_rr.Data_in1 = din1;  assign bus_sp.Data_in1 = din1;
  assign bus_rr.Ready_out = rdy;  assign bus_sp.Ready_out = rdy;

  mod_block_arbiter #(
    .BLOCK_BITS (BB),
    .STRICT_PRI (1'b0),
    .CNT_W      (8)
  ) u_dut_rr (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_rr)
  );

  mod_block_arbiter #(
    .BLOCK_BITS (BB),
    .STRICT_PRI (1'b1),
    .CNT_W      (8)
  ) u_dut_sp (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus_sp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {Grant0, Grant1, Busy, Block_done, Valid_out, Data_out, Ready_in0, Ready_in1}
  logic [7:0] out_v [2];
  assign out_v[0] = {bus_rr.Grant0, bus_rr.Grant1, bus_rr.Busy, bus_rr.Block_done,
                     bus_rr.Valid_out, bus_rr.Data_out, bus_rr.Ready_in0, bus_rr.Ready_in1};
  assign out_v[1] = {bus_sp.Grant0, bus_sp.Grant1, bus_sp.Busy, bus_sp.Block_done,
                     bus_sp.Valid_out, bus_sp.Data_out, bus_sp.Ready_in0, bus_sp.Ready_in1};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    else n_pass++;
  endtask

  // Reference model: who owns the modulator, how many bits of the block moved, who was
  // served last. Index 0 = round-robin instance, 1 = strict-priority instance.
  int m_owner [2] = '{-1, -1};
  int m_beats [2] = '{0, 0};
  int m_last  [2] = '{1, 1};

  function automatic logic [7:0] exp_outs(input int i);
    logic v, d, r0, r1, done;
    v  = (m_owner[i] == 0) ? vin0 : (m_owner[i] == 1) ? vin1 : 1'b0;
    d  = (m_owner[i] == 0) ? din0 : (m_owner[i] == 1) ? din1 : 1'b0;
    r0 = (m_owner[i] == 0) && rdy;
    r1 = (m_owner[i] == 1) && rdy;
    done = v && rdy && (m_beats[i] == BB - 1);
    return {m_owner[i] == 0, m_owner[i] == 1, m_owner[i] >= 0, done, v, d, r0, r1};
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      automatic logic [7:0] e = exp_outs(i);
      automatic int w = -1;
      if (req0 && req1) w = (i == 1) ? 0 : 1 - m_last[i];
      else if (req0) w = 0;
      else if (req1) w = 1;
      if (!rstn) begin
        m_owner[i] <= -1;
        m_beats[i] <= 0;
        m_last[i]  <= 1;
      end else if (m_owner[i] < 0 || e[4]) begin
        m_owner[i] <= w;
        m_beats[i] <= 0;
        if (w >= 0) m_last[i] <= w;
      end else if (e[3] && rdy) begin
        m_beats[i] <= m_beats[i] + 1;
      end
    end
  end

  int cyc = 0;
  int done_cnt [2] = '{0, 0};
  int g0c [2] = '{0, 0};
  int g1c [2] = '{0, 0};
  int ord0 [$];
  int ord1 [$];
  int dt0 [$];

  always @(negedge clk) begin
    cyc <= cyc + 1;
    check("rr_outs", 32'(out_v[0]), 32'(exp_outs(0)));
    check("sp_outs", 32'(out_v[1]), 32'(exp_outs(1)));
    if (out_v[0][4]) begin
      done_cnt[0] <= done_cnt[0] + 1;
      ord0.push_back(out_v[0][6] ? 1 : 0);
      dt0.push_back(cyc);
    end
    if (out_v[1][4]) begin
      done_cnt[1] <= done_cnt[1] + 1;
      ord1.push_back(out_v[1][6] ? 1 : 0);
    end
    for (int i = 0; i < 2; i++) begin
      if (out_v[i][7]) g0c[i] <= g0c[i] + 1;
      if (out_v[i][6]) g1c[i] <= g1c[i] + 1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((bus_rr.Busy || bus_sp.Busy) && n < 1000) begin
      tick();
      n++;
    end
    check(tag, 32'(bus_rr.Busy || bus_sp.Busy), 32'd0);
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
  endtask

  int g0_s, g1_s, d_s, d1_s, g1sp_s, n;
  logic [191:0] pat;

  initial begin
    rstn = 1'b0;
    {req0, req1, vin0, vin1, din0, din1, rdy} = '0;
    repeat (3) tick();
    check("reset_outs_rr", 32'(out_v[0]), 32'd0);
    check("reset_outs_sp", 32'(out_v[1]), 32'd0);
    rstn = 1'b1;
    tick();

    // Single requester, full-rate block, MSB-first data.
    pat = {$urandom(), $urandom(), $urandom(), $urandom(), $urandom(), $urandom()};
    g0_s = g0c[0];
    d_s  = done_cnt[0];
    req0 = 1'b1; vin0 = 1'b1; rdy = 1'b1; din0 = pat[191];
    tick();
    check("grant_latency", 32'(bus_rr.Grant0), 32'd1);
    req0 = 1'b0;
    for (int k = 0; k < BB; k++) begin
      din0 = pat[191-k];
      #1;
      check("data_msb_first", 32'(bus_rr.Data_out), 32'(pat[191-k]));
      tick();
    end
    tick();
    check("blk_grant0_cycles", 32'(g0c[0] - g0_s), 32'd192);
    check("blk_done_count", 32'(done_cnt[0] - d_s), 32'd1);

    // Both requesters held for four blocks.
    do_reset();
    ord0.delete(); ord1.delete(); dt0.delete();
    d_s = done_cnt[0]; g1sp_s = g1c[1];
    req0 = 1'b1; req1 = 1'b1; vin0 = 1'b1; vin1 = 1'b1; rdy = 1'b1;
    n = 0;
    while (done_cnt[0] - d_s < 4 && n < 2000) begin
      din0 = 1'($urandom()); din1 = 1'($urandom());
      tick();
      n++;
    end
    req0 = 1'b0; req1 = 1'b0;
    check("tie_done_count", 32'(done_cnt[0] - d_s), 32'd4);
    if (ord0.size() >= 4 && ord1.size() >= 4 && dt0.size() >= 4) begin
      check("rr_order_0", 32'(ord0[0]), 32'd0);
      check("rr_order_1", 32'(ord0[1]), 32'd1);
      check("rr_order_2", 32'(ord0[2]), 32'd0);
      check("rr_order_3", 32'(ord0[3]), 32'd1);
      for (int k = 0; k < 4; k++) check("sp_order", 32'(ord1[k]), 32'd0);
      for (int k = 1; k < 4; k++) check("no_bubble", 32'(dt0[k] - dt0[k-1]), 32'd192);
    end else begin
      check("tie_queue_size", 32'(ord0.size()), 32'd4);
    end
    wait_idle("tie_idle_timeout");
    check("sp_never_grant1", 32'(g1c[1] - g1sp_s), 32'd0);

    // Ready_out toggling, starting low on the first granted cycle.
    g0_s = g0c[0]; d_s = done_cnt[0]; g1_s = g1c[0];
    req0 = 1'b1; vin0 = 1'b1; rdy = 1'b0;
    tick();
    req0 = 1'b0;
    for (int k = 0; k < 2 * BB; k++) begin
      rdy = k[0];
      din0 = 1'($urandom());
      #1;
      check("ready_in0_mirror", 32'(bus_rr.Ready_in0), 32'(k[0]));
      tick();
    end
    rdy = 1'b1;
    check("stall_block_cycles", 32'(g0c[0] - g0_s), 32'd384);
    check("stall_done_count", 32'(done_cnt[0] - d_s), 32'd1);
    check("stall_no_grant1", 32'(g1c[0] - g1_s), 32'd0);

    // Valid gap of 10 cycles at bit 50 on requester 1.
    g1_s = g1c[0]; d_s = done_cnt[0];
    req1 = 1'b1; vin1 = 1'b1; rdy = 1'b1;
    tick();
    req1 = 1'b0;
    for (int k = 0; k < BB + 10; k++) begin
      vin1 = !(k >= 50 && k < 60);
      din1 = 1'($urandom());
      tick();
    end
    vin1 = 1'b1;
    check("gap_block_cycles", 32'(g1c[0] - g1_s), 32'd202);
    check("gap_done_count", 32'(done_cnt[0] - d_s), 32'd1);

    // Reset in the middle of a requester-1 block, then a tie goes to requester 0.
    req1 = 1'b1;
    tick();
    req1 = 1'b0;
    repeat (100) tick();
    d_s = done_cnt[0]; d1_s = done_cnt[1];
    rstn = 1'b0;
    tick();
    check("midreset_outs_rr", 32'(out_v[0]), 32'd0);
    check("midreset_outs_sp", 32'(out_v[1]), 32'd0);
    rstn = 1'b1;
    req0 = 1'b1; req1 = 1'b1;
    tick();
    check("midreset_no_done", 32'(done_cnt[0] - d_s + done_cnt[1] - d1_s), 32'd0);
    check("post_reset_tie_rr", 32'(bus_rr.Grant0), 32'd1);
    check("post_reset_tie_sp", 32'(bus_sp.Grant0), 32'd1);
    req0 = 1'b0; req1 = 1'b0;
    wait_idle("reset_idle_timeout");

    // Random traffic with occasional resets, checked cycle-by-cycle against the model.
    for (int k = 0; k < 4000; k++) begin
      req0 = ($urandom_range(0, 3) == 0);
      req1 = ($urandom_range(0, 3) == 0);
      vin0 = ($urandom_range(0, 3) != 0);
      vin1 = ($urandom_range(0, 3) != 0);
      din0 = 1'($urandom());
      din1 = 1'($urandom());
      rdy  = ($urandom_range(0, 3) != 0);
      rstn = ($urandom_range(0, 999) != 0);
      tick();
    end
    rstn = 1'b1;
    {req0, req1} = '0;
    rdy = 1'b1; vin0 = 1'b1; vin1 = 1'b1;
    wait_idle("random_idle_timeout");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
